dvi_timing_gen: RTL
===================

Name: dvi_timing_gen

Overview:
- Parametrised, runtime-reconfigurable video timing generator; next generation of the fixed-mode DVI sync block.
- Produces hsync/vsync with per-mode polarity, data enable, pixel coordinates, and line/frame start strobes.
- Timing arrives through a valid/ready config port, is held in a shadow register, and is applied only at a frame boundary.
- Sits between the pixel clock domain control logic and the TMDS encoder / pixel source.

Parameters:
- H_CNT_W, 12, width of horizontal counter and all horizontal config fields.
- V_CNT_W, 11, width of vertical counter and all vertical config fields.
- DEF_H_ACTIVE / DEF_H_SS / DEF_H_SE / DEF_H_TOTAL, 640 / 656 / 752 / 800, reset horizontal timing (active, sync start, sync end, total).
- DEF_V_ACTIVE / DEF_V_SS / DEF_V_SE / DEF_V_TOTAL, 480 / 490 / 492 / 525, reset vertical timing.
- DEF_HS_POL / DEF_VS_POL, 0 / 0, reset sync polarity (1 = active-high, 0 = active-low).

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  asynchronous reset, active-high
- en_i  in  1  pixel enable; counters advance only when 1
- cfg_valid_i  in  1  new timing offered
- cfg_ready_o  out  1  shadow register free
- cfg_h_active_i, cfg_h_ss_i, cfg_h_se_i, cfg_h_total_i  in  H_CNT_W each  horizontal timing
- cfg_v_active_i, cfg_v_ss_i, cfg_v_se_i, cfg_v_total_i  in  V_CNT_W each  vertical timing
- cfg_hs_pol_i, cfg_vs_pol_i  in  1 each  sync polarity
- hsync_o, vsync_o  out  1 each  syncs, polarity applied
- de_o  out  1  inside active area
- pixel_x_o  out  H_CNT_W  column; 0 outside the active area
- pixel_y_o  out  V_CNT_W  row; 0 outside the active area
- line_start_o  out  1  one-cycle strobe at h = 0
- frame_start_o  out  1  one-cycle strobe at (0,0)
- cfg_err_o  out  1  config rejected (optional feature)

Behaviour:
- **Counters.**
  - h runs 0..H_TOTAL-1 and wraps to 0.
  - v increments on the h wrap and wraps to 0 after V_TOTAL-1.
  - Both hold when en_i = 0.
- **Reset (async).**
  - Counters are set to (DEF_H_TOTAL-1, DEF_V_TOTAL-1) and the active config is loaded from the DEF_* parameters.
  - The shadow register is empty, so cfg_ready_o = 1.
  - Outputs: de_o = 0, pixel_x_o = 0, pixel_y_o = 0, line_start_o = 0, frame_start_o = 0, cfg_err_o = 0.
  - hsync_o = !DEF_HS_POL and vsync_o = !DEF_VS_POL (inactive level).
- **Output timing.**
  - All outputs are registered from the next-count value, so they are aligned with the counter with no extra latency.
  - First cycle after reset with en_i = 1: position (0,0), de_o = 1, x = 0, y = 0, line_start_o = 1, frame_start_o = 1.
- **Decode, active-config fields.**
  - hs_act = (h >= H_SS) && (h < H_SE); hsync_o = hs_act ? HS_POL : !HS_POL.
  - vsync_o uses the same rule with V_SS, V_SE and VS_POL.
  - de_o = (h < H_ACTIVE) && (v < V_ACTIVE).
  - pixel_x_o = h when h < H_ACTIVE, else 0; pixel_y_o = v when v < V_ACTIVE, else 0.
- **Strobes.**
  - line_start_o = 1 when the next h = 0 and en_i = 1.
  - frame_start_o = 1 when the next position is (0,0) and en_i = 1.
  - Both are forced to 0 on cycles with en_i = 0; all other outputs hold.
- **Config handshake.**
  - A transfer occurs when cfg_valid_i && cfg_ready_o.
  - On a transfer the fields are captured into the shadow register and cfg_ready_o drops to 0 on the next cycle.
  - The shadow is copied to the active config on the frame-wrap cycle: en_i = 1 with the current position at (H_TOTAL-1, V_TOTAL-1).
  - The new config governs decode of position (0,0) in that same cycle.
  - cfg_ready_o returns to 1 on the cycle after the wrap.
- **Simultaneous capture and wrap.** A transfer on the wrap cycle is not applied at that wrap; it waits for the following one.
- **Reset mid-frame.** The frame is aborted, any pending shadow is discarded, and the DEF_* timing is restored.
- **Arithmetic.**
  - All comparisons are unsigned, at counter width.
  - Legal config: 1 <= ACTIVE <= SS < SE <= TOTAL and TOTAL >= 2, for both axes.

Optional Feature:
- Macro name: DVI_TIMING_CFG_CHECK_EN.
- Defined:
  - Each transfer is checked against the legal-config rule for both axes.
  - A violating transfer still completes the handshake but is discarded; the shadow stays empty and cfg_ready_o stays 1.
  - cfg_err_o is set on the next cycle and stays set (sticky) until the next legal transfer, which clears it.
- Not defined:
  - No checker logic is built and cfg_err_o is tied to 0.
  - Output behaviour for an illegal config is undefined.

Test Plan:
- Reset, then en_i = 1 for 420000 cycles -> frame_start_o every 420000 cycles; 640 de_o cycles per line on 480 lines; hsync_o low 96 cycles starting at h = 656; vsync_o low for lines 490..491.
- Mid-frame, offer a config with H 4/5/6/8, V 2/3/4/6, pol 1/1 -> cfg_ready_o = 0 until the wrap; the next frame is 48 cycles long; hsync_o high only at h = 5; cfg_ready_o = 1 the cycle after the wrap.
- Toggle en_i randomly with 50% duty -> the sequence of outputs on enabled cycles is identical to the en_i = 1 run; strobes never assert while en_i = 0.
- Assert rst_i asynchronously at position (300,200) with a pending config -> outputs immediately take reset values; the next frame uses the 640x480 timing; cfg_ready_o = 1.
- Hold cfg_valid_i on the wrap cycle -> that config is applied at the second wrap, not the first.
- With DVI_TIMING_CFG_CHECK_EN defined, offer H_SS = 700, H_SE = 690 -> transfer completes, cfg_err_o = 1, timing unchanged; a following legal config -> cfg_err_o = 0.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// Runtime-reconfigurable video timing generator: sync, DE, pixel coordinates, strobes.
// Optional config legality checker: define DVI_TIMING_CFG_CHECK_EN.
module dvi_timing_gen #(
  parameter int unsigned H_CNT_W      = 12,
  parameter int unsigned V_CNT_W      = 11,
  parameter int unsigned DEF_H_ACTIVE = 640,
  parameter int unsigned DEF_H_SS     = 656,
  parameter int unsigned DEF_H_SE     = 752,
  parameter int unsigned DEF_H_TOTAL  = 800,
  parameter int unsigned DEF_V_ACTIVE = 480,
  parameter int unsigned DEF_V_SS     = 490,
  parameter int unsigned DEF_V_SE     = 492,
  parameter int unsigned DEF_V_TOTAL  = 525,
  parameter bit          DEF_HS_POL   = 1'b0,
  parameter bit          DEF_VS_POL   = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [H_CNT_W-1:0] cfg_h_active_i,
  input  logic [H_CNT_W-1:0] cfg_h_ss_i,
  input  logic [H_CNT_W-1:0] cfg_h_se_i,
  input  logic [H_CNT_W-1:0] cfg_h_total_i,
  input  logic [V_CNT_W-1:0] cfg_v_active_i,
  input  logic [V_CNT_W-1:0] cfg_v_ss_i,
  input  logic [V_CNT_W-1:0] cfg_v_se_i,
  input  logic [V_CNT_W-1:0] cfg_v_total_i,
  input  logic               cfg_hs_pol_i,
  input  logic               cfg_vs_pol_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic [H_CNT_W-1:0] pixel_x_o,
  output logic [V_CNT_W-1:0] pixel_y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               cfg_err_o
);

  typedef struct packed {
    logic [H_CNT_W-1:0] h_active;
    logic [H_CNT_W-1:0] h_ss;
    logic [H_CNT_W-1:0] h_se;
    logic [H_CNT_W-1:0] h_total;
    logic [V_CNT_W-1:0] v_active;
    logic [V_CNT_W-1:0] v_ss;
    logic [V_CNT_W-1:0] v_se;
    logic [V_CNT_W-1:0] v_total;
    logic               hs_pol;
    logic               vs_pol;
  } timing_t;

  typedef enum logic {SH_EMPTY, SH_FULL} shadow_state_e;

  localparam timing_t DEF_CFG = '{
    h_active: H_CNT_W'(DEF_H_ACTIVE), h_ss: H_CNT_W'(DEF_H_SS),
    h_se:     H_CNT_W'(DEF_H_SE),     h_total: H_CNT_W'(DEF_H_TOTAL),
    v_active: V_CNT_W'(DEF_V_ACTIVE), v_ss: V_CNT_W'(DEF_V_SS),
    v_se:     V_CNT_W'(DEF_V_SE),     v_total: V_CNT_W'(DEF_V_TOTAL),
    hs_pol:   DEF_HS_POL,             vs_pol:  DEF_VS_POL
  };

  localparam logic [H_CNT_W-1:0] H_ONE = H_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] V_ONE = V_CNT_W'(1);

  timing_t            act_cfg, shd_cfg, cfg_in, use_cfg;
  shadow_state_e      sh_state, sh_next;
  logic [H_CNT_W-1:0] h_cnt, h_nxt;
  logic [V_CNT_W-1:0] v_cnt, v_nxt;
  logic               h_last, v_last, frame_wrap, xfer, cfg_legal, load_act;
  logic               hs_act, vs_act;

  always_comb begin
    cfg_in = '{
      h_active: cfg_h_active_i, h_ss: cfg_h_ss_i, h_se: cfg_h_se_i, h_total: cfg_h_total_i,
      v_active: cfg_v_active_i, v_ss: cfg_v_ss_i, v_se: cfg_v_se_i, v_total: cfg_v_total_i,
      hs_pol: cfg_hs_pol_i, vs_pol: cfg_vs_pol_i
    };
  end

`ifdef DVI_TIMING_CFG_CHECK_EN
  always_comb begin
    cfg_legal = (cfg_in.h_active != '0) && (cfg_in.h_active <= cfg_in.h_ss) &&
                (cfg_in.h_ss < cfg_in.h_se) && (cfg_in.h_se <= cfg_in.h_total) &&
                (cfg_in.h_total > H_ONE) &&
                (cfg_in.v_active != '0) && (cfg_in.v_active <= cfg_in.v_ss) &&
                (cfg_in.v_ss < cfg_in.v_se) && (cfg_in.v_se <= cfg_in.v_total) &&
                (cfg_in.v_total > V_ONE);
  end

  // Sticky until the next legal transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cfg_err_o <= 1'b0;
    else if (xfer) cfg_err_o <= ~cfg_legal;
  end
`else
  assign cfg_legal = 1'b1;
  assign cfg_err_o = 1'b0;
`endif

  assign h_last      = (h_cnt == act_cfg.h_total - H_ONE);
  assign v_last      = (v_cnt == act_cfg.v_total - V_ONE);
  assign frame_wrap  = en_i && h_last && v_last;
  assign cfg_ready_o = (sh_state == SH_EMPTY);
  assign xfer        = cfg_valid_i && cfg_ready_o;

  // Shadow only loads from the registered state, so a capture on the wrap cycle waits a frame.
  always_comb begin
    sh_next  = sh_state;
    load_act = 1'b0;
    case (sh_state)
      SH_EMPTY: if (xfer && cfg_legal) sh_next = SH_FULL;
      SH_FULL: begin
        if (frame_wrap) begin
          sh_next  = SH_EMPTY;
          load_act = 1'b1;
        end
      end
      default: sh_next = SH_EMPTY;
    endcase
    use_cfg = load_act ? shd_cfg : act_cfg;
  end

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (en_i) begin
      if (h_last) begin
        h_nxt = '0;
        v_nxt = v_last ? '0 : v_cnt + V_ONE;
      end else begin
        h_nxt = h_cnt + H_ONE;
      end
    end
    hs_act = (h_nxt >= use_cfg.h_ss) && (h_nxt < use_cfg.h_se);
    vs_act = (v_nxt >= use_cfg.v_ss) && (v_nxt < use_cfg.v_se);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_state <= SH_EMPTY;
      shd_cfg  <= DEF_CFG;
      act_cfg  <= DEF_CFG;
    end else begin
      sh_state <= sh_next;
      if (xfer && cfg_legal) shd_cfg <= cfg_in;
      if (load_act)          act_cfg <= shd_cfg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt         <= DEF_CFG.h_total - H_ONE;
      v_cnt         <= DEF_CFG.v_total - V_ONE;
      hsync_o       <= ~DEF_HS_POL;
      vsync_o       <= ~DEF_VS_POL;
      de_o          <= 1'b0;
      pixel_x_o     <= '0;
      pixel_y_o     <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (en_i) begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hsync_o       <= hs_act ? use_cfg.hs_pol : ~use_cfg.hs_pol;
      vsync_o       <= vs_act ? use_cfg.vs_pol : ~use_cfg.vs_pol;
      de_o          <= (h_nxt < use_cfg.h_active) && (v_nxt < use_cfg.v_active);
      pixel_x_o     <= (h_nxt < use_cfg.h_active) ? h_nxt : '0;
      pixel_y_o     <= (v_nxt < use_cfg.v_active) ? v_nxt : '0;
      line_start_o  <= (h_nxt == '0);
      frame_start_o <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule
